// File: rtl/csr_access_ctrl.sv
// csr_access_ctrl: sequences EXU CSR ops (csrrw/s/c, ecall, mret) into
// CSR file read/modify/write accesses, rd writeback and PC redirects.
// Optional build macro: CSR_ADDR_CHECK_EN (reject unimplemented CSR addresses).
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   op_valid/op_ready   EXU handshake; op_code/op_csr_addr/op_src/op_rs1_zero/op_pc
//   csr_addr/csr_we/csr_wdata/csr_rdata   CSR file access
//   csr_is_ecall/csr_pc/csr_mtvec/csr_mepc trap interface
//   wb_valid/wb_data/illegal              rd writeback
//   redirect_valid/redirect_pc            PC redirect
module csr_access_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [2:0]       op_code,
    input  logic [11:0]      op_csr_addr,
    input  logic [WIDTH-1:0] op_src,
    input  logic             op_rs1_zero,
    input  logic [WIDTH-1:0] op_pc,
    output logic [11:0]      csr_addr,
    output logic             csr_we,
    output logic [WIDTH-1:0] csr_wdata,
    input  logic [WIDTH-1:0] csr_rdata,
    output logic             csr_is_ecall,
    output logic [WIDTH-1:0] csr_pc,
    input  logic [WIDTH-1:0] csr_mtvec,
    input  logic [WIDTH-1:0] csr_mepc,
    output logic             wb_valid,
    output logic [WIDTH-1:0] wb_data,
    output logic             redirect_valid,
    output logic [WIDTH-1:0] redirect_pc,
    output logic             illegal
);

    localparam logic [2:0] OP_RW    = 3'd1;
    localparam logic [2:0] OP_RS    = 3'd2;
    localparam logic [2:0] OP_RC    = 3'd3;
    localparam logic [2:0] OP_ECALL = 3'd4;
    localparam logic [2:0] OP_MRET  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WRITE,
        S_TRAP,
        S_RESP
    } state_t;

    state_t           r_state;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_src;
    logic             r_rs1_zero;
    logic [WIDTH-1:0] r_old;
    logic             r_ready;
    logic [11:0]      r_addr;
    logic             r_we;
    logic [WIDTH-1:0] r_wdata;
    logic             r_ecall;
    logic [WIDTH-1:0] r_pc;
    logic             r_wb_valid;
    logic [WIDTH-1:0] r_wb_data;
    logic             r_redir_valid;
    logic [WIDTH-1:0] r_redir_pc;
    logic             r_illegal;

    logic             w_is_csr;
    logic             w_addr_ok;
    logic [WIDTH-1:0] w_mod;

    assign w_is_csr = (op_code == OP_RW) || (op_code == OP_RS) ||
                      (op_code == OP_RC);

`ifdef CSR_ADDR_CHECK_EN
    // Only mstatus, mtvec, mepc and mcause are implemented.
    assign w_addr_ok = (op_csr_addr == 12'h300) || (op_csr_addr == 12'h305) ||
                       (op_csr_addr == 12'h341) || (op_csr_addr == 12'h342);
`else
    assign w_addr_ok = 1'b1;
`endif

    // New CSR value is formed from the live read data so that csr_wdata
    // is registered in the same edge that captures old_q.
    always_comb begin
        w_mod = r_src;
        case (r_op)
            OP_RS:   w_mod = csr_rdata | r_src;
            OP_RC:   w_mod = csr_rdata & ~r_src;
            default: w_mod = r_src;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_op          <= 3'd0;
            r_src         <= '0;
            r_rs1_zero    <= 1'b0;
            r_old         <= '0;
            r_ready       <= 1'b1;
            r_addr        <= 12'd0;
            r_we          <= 1'b0;
            r_wdata       <= '0;
            r_ecall       <= 1'b0;
            r_pc          <= '0;
            r_wb_valid    <= 1'b0;
            r_wb_data     <= '0;
            r_redir_valid <= 1'b0;
            r_redir_pc    <= '0;
            r_illegal     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (op_valid && r_ready) begin
                        r_op       <= op_code;
                        r_addr     <= op_csr_addr;
                        r_src      <= op_src;
                        r_rs1_zero <= op_rs1_zero;
                        r_pc       <= op_pc;
                        r_ready    <= 1'b0;
                        if (w_is_csr && w_addr_ok) begin
                            r_state <= S_READ;
                        end else if (op_code == OP_ECALL) begin
                            r_ecall <= 1'b1;
                            r_state <= S_TRAP;
                        end else if (op_code == OP_MRET) begin
                            r_redir_valid <= 1'b1;
                            r_redir_pc    <= csr_mepc;
                            r_state       <= S_RESP;
                        end else begin
                            // Illegal op_code or rejected CSR address.
                            r_wb_valid <= 1'b1;
                            r_wb_data  <= '0;
                            r_illegal  <= 1'b1;
                            r_state    <= S_RESP;
                        end
                    end
                end
                S_READ: begin
                    r_old   <= csr_rdata;
                    r_wdata <= w_mod;
                    // Set/clear with a zero source must not write.
                    r_we    <= !(r_rs1_zero && (r_op != OP_RW));
                    r_state <= S_WRITE;
                end
                S_WRITE: begin
                    r_we       <= 1'b0;
                    r_wb_valid <= 1'b1;
                    r_wb_data  <= r_old;
                    r_state    <= S_RESP;
                end
                S_TRAP: begin
                    r_ecall       <= 1'b0;
                    r_redir_valid <= 1'b1;
                    r_redir_pc    <= csr_mtvec;
                    r_state       <= S_RESP;
                end
                S_RESP: begin
                    r_wb_valid    <= 1'b0;
                    r_redir_valid <= 1'b0;
                    r_illegal     <= 1'b0;
                    r_ready       <= 1'b1;
                    r_state       <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign op_ready       = r_ready;
    assign csr_addr       = r_addr;
    // Gate with rst so a reset landing in WRITE never commits the write.
    assign csr_we         = r_we & ~rst;
    assign csr_wdata      = r_wdata;
    assign csr_is_ecall   = r_ecall;
    assign csr_pc         = r_pc;
    assign wb_valid       = r_wb_valid;
    assign wb_data        = r_wb_data;
    assign redirect_valid = r_redir_valid;
    assign redirect_pc    = r_redir_pc;
    assign illegal        = r_illegal;

endmodule
